// File: rtl/arm_pkg.sv
// Shared encodings for the operand shifter: shift types and controller states.
package arm_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam int CNT_W = 6;

endpackage

// File: rtl/operand_shifter_shift_step.sv
// One combinational shifter slice: shifts by 0..STEP positions, reports the last bit out.
module shift_step
    import arm_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic [31:0] value_i,
    input  shift_t      type_i,
    input  logic        rrx_i,
    input  logic        rrx_bit_i,
    input  logic [2:0]  amt_i,
    output logic [31:0] value_o,
    output logic        last_o
);

    logic [31:0] v;
    logic        l;

    always_comb begin
        v = value_i;
        l = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (3'(i) < amt_i) begin
                case (type_i)
                    SH_LSL: begin
                        l = v[31];
                        v = {v[30:0], 1'b0};
                    end
                    SH_LSR: begin
                        l = v[0];
                        v = {1'b0, v[31:1]};
                    end
                    SH_ASR: begin
                        l = v[0];
                        v = {v[31], v[31:1]};
                    end
                    default: begin
                        // RRX rotates the captured carry in instead of bit 0
                        l = v[0];
                        v = {(rrx_i ? rrx_bit_i : v[0]), v[31:1]};
                    end
                endcase
            end
        end
        value_o = v;
        last_o  = l;
    end

endmodule

// File: rtl/operand_shifter.sv
// Multi-cycle ARM-style operand shifter (LSL/LSR/ASR/ROR, rotated immediate), STEP bits per cycle.
// Define ARM_SHIFT_SPECIAL_EN to decode register amount 0 as LSR#32 / ASR#32 / RRX.
//
// state  | meaning
// IDLE   | waiting for start
// SHIFT  | shifting, remaining count > 0, busy high
// DONE   | result valid, done pulse; may accept a new start
module operand_shifter
    import arm_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        imm_mode,
    input  logic [1:0]  shift_type,
    input  logic [4:0]  amount,
    input  logic [31:0] operand,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        carry_out,
    output logic        busy,
    output logic        done
);

    if (!(STEP == 1 || STEP == 2 || STEP == 4)) begin : g_step_check
        $error("operand_shifter: STEP must be 1, 2 or 4");
    end

    localparam logic [2:0] STEP3 = 3'(STEP);

    state_t           state_q, state_d;
    logic [31:0]      result_q, result_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    shift_t           type_q, type_d;
    logic             rrx_q, rrx_d;

    logic [CNT_W-1:0] n_dec;
    logic [31:0]      src_dec;
    shift_t           type_dec;
    logic             rrx_dec;

    always_comb begin
        type_dec = shift_t'(shift_type);
        src_dec  = operand;
        n_dec    = {1'b0, amount};
        rrx_dec  = 1'b0;
        if (imm_mode) begin
            type_dec = SH_ROR;
            src_dec  = {24'b0, operand[7:0]};
            n_dec    = {1'b0, operand[11:8], 1'b0};
        end
`ifdef ARM_SHIFT_SPECIAL_EN
        else if (amount == 5'd0) begin
            case (type_dec)
                SH_LSR, SH_ASR: n_dec = 6'd32;
                SH_ROR: begin
                    n_dec   = 6'd1;
                    rrx_dec = 1'b1;
                end
                default: ;
            endcase
        end
`endif
    end

    logic [2:0]       step_amt;
    logic [31:0]      step_val;
    logic             step_last;
    logic [CNT_W-1:0] rem_next;

    assign step_amt = (rem_q < {3'b0, STEP3}) ? rem_q[2:0] : STEP3;
    assign rem_next = rem_q - {3'b0, step_amt};

    shift_step #(.STEP(STEP)) u_step (
        .value_i   (result_q),
        .type_i    (type_q),
        .rrx_i     (rrx_q),
        .rrx_bit_i (carry_q),
        .amt_i     (step_amt),
        .value_o   (step_val),
        .last_o    (step_last)
    );

    logic accept;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        rem_d    = rem_q;
        type_d   = type_q;
        rrx_d    = rrx_q;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE: accept = start;
            ST_SHIFT: begin
                busy     = 1'b1;
                result_d = step_val;
                carry_d  = step_last;
                rem_d    = rem_next;
                if (rem_next == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                accept = start;
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            result_d = src_dec;
            carry_d  = carry_in;
            rem_d    = n_dec;
            type_d   = type_dec;
            rrx_d    = rrx_dec;
            state_d  = (n_dec == '0) ? ST_DONE : ST_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            rem_q    <= '0;
            type_q   <= SH_LSL;
            rrx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            rem_q    <= rem_d;
            type_q   <= type_d;
            rrx_q    <= rrx_d;
        end
    end

    assign result    = result_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_operand_shifter.sv
// Scoreboard bench for operand_shifter: STEP=1 and STEP=4 instances share the operand inputs.
module tb_operand_shifter;

    logic        clk = 1'b0;
    logic        reset_n, start1, start4, imm_mode, carry_in;
    logic [1:0]  shift_type;
    logic [4:0]  amount;
    logic [31:0] operand;
    logic [31:0] result1, result4;
    logic        carry1, carry4, busy1, busy4, done1, done4;

    always #5 clk = ~clk;

    operand_shifter #(.STEP(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .imm_mode(imm_mode),
        .shift_type(shift_type), .amount(amount), .operand(operand), .carry_in(carry_in),
        .result(result1), .carry_out(carry1), .busy(busy1), .done(done1)
    );

    operand_shifter #(.STEP(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .imm_mode(imm_mode),
        .shift_type(shift_type), .amount(amount), .operand(operand), .carry_in(carry_in),
        .result(result4), .carry_out(carry4), .busy(busy4), .done(done4)
    );

    typedef struct {
        logic [31:0] res;
        logic        cy;
        int          edge_no;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_result", result1, e.res);
                chk("dut1_carry", {31'b0, carry1}, {31'b0, e.cy});
                chk("dut1_done_edge", cyc, e.edge_no);
            end
        end
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4_unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("dut4_result", result4, e.res);
                chk("dut4_carry", {31'b0, carry4}, {31'b0, e.cy});
                chk("dut4_done_edge", cyc, e.edge_no);
            end
        end
    end

    // Called just after a negedge; the next posedge is the accepting edge.
    task automatic issue(input bit to1, input bit to4, input bit im, input logic [1:0] ty,
                         input logic [4:0] am, input logic [31:0] op, input bit ci,
                         input logic [31:0] er, input bit ec, input int n);
        exp_t e;
        imm_mode   = im;
        shift_type = ty;
        amount     = am;
        operand    = op;
        carry_in   = ci;
        start1     = to1;
        start4     = to4;
        e.res      = er;
        e.cy       = ec;
        if (to1) begin
            e.edge_no = cyc + 1 + n;
            q1.push_back(e);
        end
        if (to4) begin
            e.edge_no = cyc + 1 + (n + 3) / 4;
            q4.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (q1.size() == 0 && q4.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (q1.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL done_timeout actual=pending %0d/%0d required=0/0", q1.size(), q4.size());
            q1.delete();
            q4.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input bit im, input logic [1:0] ty, input logic [4:0] am,
                       input logic [31:0] op, input bit ci, input logic [31:0] er,
                       input bit ec, input int n);
        issue(1'b1, 1'b1, im, ty, am, op, ci, er, ec, n);
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        wait_idle();
    endtask

    initial begin
        reset_n    = 1'b0;
        start1     = 1'b0;
        start4     = 1'b0;
        imm_mode   = 1'b0;
        shift_type = 2'b00;
        amount     = 5'd0;
        operand    = 32'h0;
        carry_in   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_result1", result1, 32'h0);
        chk("rst_carry1", {31'b0, carry1}, 32'h0);
        chk("rst_busy1", {31'b0, busy1}, 32'h0);
        chk("rst_done1", {31'b0, done1}, 32'h0);
        chk("rst_result4", result4, 32'h0);
        chk("rst_busy4", {31'b0, busy4}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // LSL #4 on STEP=1 with start held (and inputs changed) during SHIFT
        issue(1'b1, 1'b0, 1'b0, 2'b00, 5'd4, 32'h8000_000F, 1'b0, 32'h0000_00F0, 1'b0, 4);
        @(negedge clk);
        operand    = 32'hFFFF_FFFF;
        shift_type = 2'b11;
        amount     = 5'd1;
        carry_in   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("held_start_busy", {31'b0, busy1}, 32'h1);
            @(negedge clk);
        end
        start1 = 1'b0;
        wait_idle();

        run(1'b0, 2'b10, 5'd8,  32'h8000_1200, 1'b1, 32'hFF80_0012, 1'b0, 8);
        run(1'b1, 2'b00, 5'd0,  32'h0000_02FF, 1'b0, 32'hF000_000F, 1'b1, 4);
        run(1'b1, 2'b01, 5'd7,  32'h0000_0F01, 1'b1, 32'h0000_0004, 1'b0, 30);
        run(1'b1, 2'b10, 5'd3,  32'hFFFF_00AB, 1'b1, 32'h0000_00AB, 1'b1, 0);
        run(1'b0, 2'b01, 5'd1,  32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1, 1);
        run(1'b0, 2'b00, 5'd31, 32'h0000_0003, 1'b0, 32'h8000_0000, 1'b1, 31);
        run(1'b0, 2'b11, 5'd8,  32'h1234_5678, 1'b1, 32'h7812_3456, 1'b0, 8);
        run(1'b0, 2'b10, 5'd5,  32'h7FFF_FFF0, 1'b0, 32'h03FF_FFFF, 1'b1, 5);
        run(1'b0, 2'b00, 5'd0,  32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 0);
`ifdef ARM_SHIFT_SPECIAL_EN
        run(1'b0, 2'b11, 5'd0,  32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1, 1);
        run(1'b0, 2'b01, 5'd0,  32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1, 32);
        run(1'b0, 2'b10, 5'd0,  32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 32);
`else
        run(1'b0, 2'b11, 5'd0,  32'h0000_0003, 1'b1, 32'h0000_0003, 1'b1, 0);
        run(1'b0, 2'b01, 5'd0,  32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0, 0);
        run(1'b0, 2'b10, 5'd0,  32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 0);
`endif

        // Back-to-back: new start accepted directly out of DONE
        issue(1'b1, 1'b0, 1'b0, 2'b01, 5'd3, 32'h0000_000F, 1'b0, 32'h0000_0001, 1'b1, 3);
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done1 === 1'b1) break;
            @(negedge clk);
        end
        chk("b2b_first_done_seen", {31'b0, done1}, 32'h1);
        issue(1'b1, 1'b0, 1'b0, 2'b10, 5'd1, 32'h8000_0001, 1'b0, 32'hC000_0000, 1'b1, 1);
        @(negedge clk);
        start1 = 1'b0;
        wait_idle();

        // Reset on the 10th edge of an LSR #31, start held throughout
        issue(1'b0, 1'b0, 1'b0, 2'b01, 5'd31, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 0);
        start1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("pre_reset_busy", {31'b0, busy1}, 32'h1);
        end
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_result", result1, 32'h0);
        chk("mid_reset_carry", {31'b0, carry1}, 32'h0);
        chk("mid_reset_busy", {31'b0, busy1}, 32'h0);
        chk("mid_reset_done", {31'b0, done1}, 32'h0);
        @(negedge clk);
        chk("reset_ignores_start", {31'b0, busy1}, 32'h0);
        start1  = 1'b0;
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_reset_busy", {31'b0, busy1}, 32'h0);
        chk("post_reset_result", result1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_shifter.md
OPERAND_SHIFTER -- requirements
Module: operand_shifter

Interface
REQ-001 SHALL have parameter STEP, default 1, meaning shift positions processed per cycle; only 1, 2 or 4 are legal.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a new operation.
REQ-005 SHALL have port imm_mode, input, 1 bit: 1 selects rotated-immediate operand, 0 selects shifted register.
REQ-006 SHALL have port shift_type, input, 2 bits: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-007 SHALL have port amount, input, 5 bits: register-mode shift amount.
REQ-008 SHALL have port operand, input, 32 bits: value to shift; in imm_mode, bits [7:0] are the immediate and bits [11:8] are the rotate field.
REQ-009 SHALL have port carry_in, input, 1 bit: current C flag.
REQ-010 SHALL have port result, output, 32 bits: shifted operand that drives ALU inputB.
REQ-011 SHALL have port carry_out, output, 1 bit: shifter carry that drives ALU carryIn.
REQ-012 SHALL have port busy, output, 1 bit: high while shifting.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when result is valid.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE; busy is high only in SHIFT, and done is high only in DONE.
REQ-015 SHALL accept start only in IDLE or DONE; start in SHIFT SHALL be ignored without disturbing the operation in progress.
REQ-016 SHALL, on the accepting edge, capture operand, carry_in, type and effective count n (imm_mode: n = 2*operand[11:8], type ROR, source zero-extended operand[7:0]).
REQ-017 SHALL move from the accepting edge to DONE if n = 0, else to SHIFT with a 6-bit remaining counter equal to n.
REQ-018 SHALL, on each SHIFT edge, shift by min(STEP, remaining), decrement remaining by the same amount, and enter DONE when remaining reaches 0.
REQ-019 SHALL assert done in the cycle after edge 1+ceil(n/STEP), counting the accepting edge as edge 1.
REQ-020 SHALL leave from DONE to IDLE after one cycle unless start is high, in which case it accepts the new operation.
REQ-021 SHALL hold result and carry_out stable from DONE until the next accepting edge.
REQ-022 SHALL implement LSL as zero fill and LSR as zero fill.
REQ-023 SHALL implement ASR as fill with bit 31 of the captured operand.
REQ-024 SHALL implement ROR with bits shifted out of bit 0 re-entering at bit 31.
REQ-025 SHALL set carry_out for n > 0 to the last bit shifted out (LSL: operand[32-n]; LSR/ASR: operand[n-1]; ROR: result[31]).
REQ-026 SHALL, for n = 0 (including imm rotate 0), set result = source and carry_out = captured carry_in, unless REQ-030 applies.

Reset
REQ-027 SHALL, when reset_n is low at a clock edge, enter IDLE with result = 0, carry_out = 0, busy = 0, done = 0 and remaining = 0.
REQ-028 SHALL abort any operation when reset is asserted mid-SHIFT, with no done pulse afterwards.
REQ-029 SHALL ignore start while reset_n is low.

Configuration
REQ-030 SHALL, with macro ARM_SHIFT_SPECIAL_EN defined, decode register-mode amount = 0 as follows:
- LSR becomes LSR #32 (result 0, carry_out operand[31]).
- ASR becomes ASR #32 (result all operand[31], carry_out operand[31]).
- ROR becomes RRX (result {carry_in, operand[31:1]}, carry_out operand[0], exactly one SHIFT edge regardless of STEP).
- LSL #0 and imm_mode are unaffected.
REQ-031 SHALL, without ARM_SHIFT_SPECIAL_EN, treat every zero amount per REQ-026.

Structure
REQ-032 SHALL place the shift-type encoding (LSL/LSR/ASR/ROR) and the FSM state encoding in shared package arm_pkg.
REQ-033 SHALL contain one combinational sub-module, shift_step, which performs one shift of 0..STEP positions and returns the shifted value and last-out bit.

Verification
REQ-034 SHALL cover: STEP=1, LSL, amount 4, operand 0x8000_000F, carry_in 0 -> done after edge 5, result 0x0000_00F0, carry_out 0.
REQ-035 SHALL cover: STEP=4, ASR, amount 8, operand 0x8000_1200 -> done after edge 3, result 0xFF80_0012, carry_out 0.
REQ-036 SHALL cover: imm_mode, operand 0x0000_02FF (rotate field 2, n=4) -> result 0xF000_000F, carry_out 1.
REQ-037 SHALL cover: with ARM_SHIFT_SPECIAL_EN, ROR amount 0, operand 0x0000_0003, carry_in 1 -> result 0x8000_0001, carry_out 1; without the macro -> result 0x0000_0003, carry_out 1.
REQ-038 SHALL cover: STEP=1, LSR amount 31 started, reset_n low on edge 10 -> IDLE, result 0, no done pulse; start held during SHIFT -> ignored.
